// File: rtl/bcd_to_bin_if.sv
// Request/response bundle for the BCD-to-binary converter: start/bcd in, busy/done/bin/err out.
interface bcd_to_bin_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin;
    logic                  err;

    modport master (output start, bcd, input busy, done, bin, err);
    modport slave  (input start, bcd, output busy, done, bin, err);
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative reverse double-dabble converter: packed BCD in, unsigned binary out after BIN_W shifts.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; start is sampled here
// S_SHIFT | one shift-and-correct step per cycle, busy=1
// S_DONE  | done pulse with a fresh bin; a new start is accepted here
// S_FAIL  | done pulse with err=1 and bin=0 for an illegal digit
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    bcd_to_bin_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

    logic [1:0]       state;
    logic [BCD_W-1:0] d;
    logic [BCD_W-1:0] d_shift;
    logic [BCD_W-1:0] d_next;
    logic [BIN_W-1:0] b;
    logic [BIN_W-1:0] b_next;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin_q;
    logic             err_q;
    logic             bcd_legal;
    logic             accept;
    logic             last_shift;

    always_comb begin
        bcd_legal = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) begin
                bcd_legal = 1'b0;
            end
        end
    end

    // Shift first, then pull each digit that landed at >= 8 back into decimal range.
    always_comb begin
        {d_shift, b_next} = {d, b} >> 1;
        d_next = d_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (d_shift[4*i +: 4] >= 4'd8) begin
                d_next[4*i +: 4] = d_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    assign accept     = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            d     <= '0;
            b     <= '0;
            cnt   <= '0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        d   <= bus.bcd;
                        b   <= '0;
                        cnt <= '0;
                        if (bcd_legal) begin
                            state <= S_SHIFT;
                        end else begin
                            state <= S_FAIL;
                            bin_q <= '0;
                            err_q <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    d   <= d_next;
                    b   <= b_next;
                    cnt <= cnt + 1'b1;
                    // The result is captured from the final shift so it is valid in the done cycle.
                    if (last_shift) begin
                        state <= S_DONE;
                        bin_q <= b_next;
                        err_q <= 1'b0;
                    end
                end
                S_FAIL: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state == S_SHIFT);
    assign bus.done = (state == S_DONE) || (state == S_FAIL);
    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and exhaustive bench for bcd_to_bin with a cycle-level decimal reference model.
module tb_bcd_to_bin;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit bcd_ok(input logic [11:0] v);
        bcd_ok = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
    endfunction

    function automatic int bcd_val(input logic [11:0] v);
        bcd_val = 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    // Reference model: a conversion is a fixed-length busy period followed by a decimal result.
    int m_left = 0;
    int m_pend = 0;
    int m_bin  = 0;
    bit m_err  = 1'b0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_pend = 0;
            m_bin  = 0;
            m_err  = 1'b0;
            m_done = 1'b0;
        end else begin
            bit can_take;
            bit nd;
            can_take = (m_left == 0) && !(m_done && m_err);
            nd = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    nd    = 1'b1;
                    m_bin = m_pend;
                    m_err = 1'b0;
                end
            end else if (bus.start && can_take) begin
                if (bcd_ok(bus.bcd)) begin
                    m_left = BIN_W;
                    m_pend = bcd_val(bus.bcd);
                end else begin
                    nd    = 1'b1;
                    m_bin = 0;
                    m_err = 1'b1;
                end
            end
            m_done = nd;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", int'(bus.busy), int'(m_left > 0));
        chk("cyc_done", int'(bus.done), int'(m_done));
        chk("cyc_bin",  int'(bus.bin),  m_bin);
        chk("cyc_err",  int'(bus.err),  int'(m_err));
    end

    // Issues one request and returns at the negedge where done is visible.
    task automatic do_conv(input logic [11:0] v, input int eb, input bit ee,
                           input int elat, input bit b2b, input string tag);
        int n;
        if (!b2b) @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = v;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_bin"}, int'(bus.bin), eb);
        chk({tag, "_err"}, int'(bus.err), int'(ee));
    endtask

    initial begin
        int n;
        int dones;
        bit seen;
        int gap;
        logic [11:0] v;

        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.bcd   = '0;
        #1 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_bin",  int'(bus.bin),  0);
        chk("rst_err",  int'(bus.err),  0);
        #2 rst_n = 1'b1;

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 12'h999;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_bin",  int'(bus.bin),  0);
        chk("midrst_err",  int'(bus.err),  0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("midrst_no_done", dones, 0);
        do_conv(12'h123, 123, 1'b0, 11, 1'b0, "after_rst");

        do_conv(12'h000, 0,   1'b0, 11, 1'b0, "v000");
        do_conv(12'h001, 1,   1'b0, 11, 1'b0, "v001");
        do_conv(12'h255, 255, 1'b0, 11, 1'b0, "v255");
        do_conv(12'h999, 999, 1'b0, 11, 1'b0, "v999");

        do_conv(12'h1A3, 0,   1'b1, 1,  1'b0, "ill_1a3");
        do_conv(12'h042, 42,  1'b0, 11, 1'b0, "v042");
        do_conv(12'hF00, 0,   1'b1, 1,  1'b0, "ill_f00");
        do_conv(12'h00A, 0,   1'b1, 1,  1'b0, "ill_00a");
        do_conv(12'h870, 870, 1'b0, 11, 1'b0, "v870");

        // Start pulse with a different value while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 12'h512;
        n = 0;
        seen = 1'b0;
        while (n < 30 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else chk("coll_busy", int'(bus.busy), 1);
            bus.start = (n == 4);
            bus.bcd   = (n == 4) ? 12'h777 : 12'h000;
        end
        chk("coll_latency", n, 11);
        chk("coll_bin", int'(bus.bin), 512);
        bus.start = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("coll_single_done", dones, 0);

        // Back-to-back: the second start is raised in the done cycle of the first.
        do_conv(12'h100, 100, 1'b0, 11, 1'b0, "b2b_first");
        do_conv(12'h099, 99,  1'b0, 11, 1'b1, "b2b_second");

        // Every legal input with random idle gaps; a zero gap issues back-to-back.
        for (int i = 0; i < 1000; i++) begin
            v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            do_conv(v, i, 1'b0, 11, (gap == 0), "exh");
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Iterative BCD-to-binary converter using the reverse double-dabble algorithm (shift right, then subtract 3 from any BCD digit ≥ 8). It is the inverse of the binary-to-BCD path used for display. It converts packed decimal digits from keypad or switch entry back into an unsigned binary value for arithmetic. One conversion takes BIN_W shift cycles under a start/busy/done handshake.

## Interface
- DIGITS, default 3: number of packed BCD digits on the input.
- BIN_W, default 10: binary result width. Must equal ceil(log2(10^DIGITS)); 10 for 3 digits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion. Sampled only when busy=0.
- bcd  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]. Sampled on the accepting edge only.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bin/err update.
- bin  output  BIN_W  result. Held until the next done.
- err  output  1  last request contained a digit > 9. Held until the next done.

## Operation
- Working register {d, b}: d is 4*DIGITS bits (BCD part), b is BIN_W bits (binary part). A counter cnt runs 0..BIN_W.
- States:
  - IDLE → SHIFT on an accepted start with all digits ≤ 9.
  - IDLE → FAIL on an accepted start with any digit > 9.
  - SHIFT → SHIFT while cnt < BIN_W-1.
  - SHIFT → DONE after the BIN_W-th shift.
  - FAIL → IDLE.
  - DONE → IDLE, or DONE → SHIFT/FAIL if start=1 in DONE (back-to-back requests are accepted).
- Accept: load d=bcd, b=0, cnt=0.
- Each SHIFT cycle:
  - {d,b} = {d,b} >> 1, with 0 shifted into the d MSB.
  - Then every 4-bit digit of the shifted d that is ≥ 8 has 3 subtracted (4-bit, no borrow across digits).
  - Then cnt += 1.
- DONE: bin ← b, err ← 0, done=1. After BIN_W shifts d is all zero.
- FAIL: bin ← 0, err ← 1, done=1. No shifting.
- busy=1 in SHIFT only. done=1 in DONE and FAIL only.
- start while busy=1 is ignored. It is neither queued nor does it disturb the conversion. The bcd input may change freely during SHIFT.
- Arithmetic: unsigned only. The result never exceeds 10^DIGITS−1, so no overflow is possible with a legal BIN_W.

## Timing
- Reset (async assert, any state, including mid-conversion):
  - state=IDLE, busy=0, done=0, bin=0, err=0, cnt=0, {d,b}=0.
  - The in-flight conversion is discarded and no done is produced.
- Reset deassertion is synchronous to clk by the system. First start is accepted on the first edge after release.
- Start accepted at edge E0 (legal digits):
  - busy=1 from after E0 through the edge E_BIN_W.
  - DONE occupies the cycle after E_BIN_W: done=1 and bin valid, busy=0.
  - Start-to-done latency is BIN_W+1 edges (11 for defaults).
- Illegal digits: done=1 and err=1 in the cycle after E0 (latency 1). bin reads 0.
- bin and err are registered outputs. They change only on the edge entering DONE/FAIL and remain stable in between.
- Back-to-back: start=1 during the done cycle is accepted, so throughput is one result per BIN_W+1 cycles.

## Test plan
- Reset mid-conversion: bcd=0x999, start, then assert rst_n=0 at shift 5 → busy/done/bin/err all 0 immediately; no done after release; next start of 0x123 → bin=123.
- Basic values: bcd=0x000 → bin=0; 0x001 → 1; 0x255 → 255 (0x0FF); 0x999 → 999 (0x3E7). Each done exactly 11 cycles after start, err=0.
- Illegal digit: bcd=0x1A3 → done the next cycle, err=1, bin=0. Then 0x042 → bin=42, err=0.
- Busy collision: start 0x512, pulse start with bcd=0x777 at cycle 4 → single done with bin=512; busy never drops early.
- Back-to-back: start 0x100, then hold start=1 with 0x099 on the done cycle → bins 100 then 99, done pulses 11 cycles apart.
- Exhaustive: all 1000 legal inputs compared against a decimal model, with random idle gaps between requests.
